tick_latch_bank: RTL and testbench

- Parametrised successor to the single-bit divided-clock D latch on the Vaman (EOS S3) board.
- Holds a WIDTH-bit data bank whose update timing comes from an internal divider on the fabric clock (Sys_Clk0), rather than from a generated clock.
- Selectable capture modes: level/transparent, rising-edge, falling-edge and pass-through. Adds input synchronisation, freeze and a capture strobe/counter.
- Fully synchronous to one clock: no inferred latches, no derived clocks. Drives board LEDs and downstream logic.

---
 rtl/tick_latch_pkg.sv | 17 +
 rtl/clk_tick_div.sv | 45 ++++
 rtl/tick_latch_bank.sv | 87 ++++++++
 tb/tb_tick_latch_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tick_latch_pkg.sv
// Shared constants and helpers for the tick-driven latch bank and its clock divider.
package tick_latch_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_THRU  = 2'b11;

    // Width of a counter that must reach div_count-1; never narrower than one bit.
    function automatic int unsigned div_cnt_width(input int unsigned div_count);
        if (div_count <= 2) begin
            return 1;
        end
        return $clog2(div_count);
    endfunction

endpackage

// File: rtl/clk_tick_div.sv
// Free-running divider: slow_clk is a square wave of period 2*DIV_COUNT fabric cycles and
// tick is high for the single cycle just before each slow_clk toggle.
module clk_tick_div
    import tick_latch_pkg::*;
#(
    parameter int unsigned DIV_COUNT = 30000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic slow_clk
);

    localparam int unsigned CntW = div_cnt_width(DIV_COUNT);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV_COUNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            slow_q, slow_d;
    logic            wrap;

    always_comb begin
        wrap   = (cnt_q == CntMax);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        slow_d = wrap ? ~slow_q : slow_q;
        // Registered from the next count so tick is high exactly while cnt sits at its maximum.
        tick_d = (cnt_d == CntMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            slow_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            slow_q <= slow_d;
        end
    end

    assign tick     = tick_q;
    assign slow_clk = slow_q;

endmodule

// File: rtl/tick_latch_bank.sv
// WIDTH-bit data bank loaded from synchronised inputs under a selectable capture mode,
// with timing taken from an internal divider on the single fabric clock.
module tick_latch_bank
    import tick_latch_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DIV_COUNT   = 30000000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             freeze,
    output logic [WIDTH-1:0] q,
    output logic             slow_clk,
    output logic             tick,
    output logic             upd,
    output logic [CNT_W-1:0] cap_cnt
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  d_s;
    logic [WIDTH-1:0]                  q_q, q_d;
    logic                              upd_q, upd_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              ld;

    clk_tick_div #(
        .DIV_COUNT (DIV_COUNT)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .slow_clk (slow_clk)
    );

    // Per-bit synchroniser; bits may resolve on different cycles.
    always_comb begin
        sync_d[0] = d;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign d_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        ld = 1'b0;
        unique case (mode)
            MODE_LEVEL: ld = slow_clk;
            MODE_RISE:  ld = tick & ~slow_clk;
            MODE_FALL:  ld = tick & slow_clk;
            MODE_THRU:  ld = 1'b1;
        endcase
        // A tick seen while frozen is dropped, not deferred.
        if (freeze) begin
            ld = 1'b0;
        end
    end

    always_comb begin
        q_d   = ld ? d_s : q_q;
        upd_d = ld;
        cnt_d = cnt_q + CNT_W'(ld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            q_q    <= '0;
            upd_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            q_q    <= q_d;
            upd_q  <= upd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q       = q_q;
    assign upd     = upd_q;
    assign cap_cnt = cnt_q;

endmodule

// File: tb/tb_tick_latch_bank.sv
// Randomised scoreboard bench for tick_latch_bank against an arithmetic reference model.
module tb_tick_latch_bank;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned DIV_COUNT   = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 8;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             slow;
        logic             tick;
        logic             upd;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] d;
    logic [1:0]       mode;
    logic             freeze;
    logic [WIDTH-1:0] q;
    logic             slow_clk;
    logic             tick;
    logic             upd;
    logic [CNT_W-1:0] cap_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    tick_latch_bank #(
        .WIDTH       (WIDTH),
        .DIV_COUNT   (DIV_COUNT),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .mode     (mode),
        .freeze   (freeze),
        .q        (q),
        .slow_clk (slow_clk),
        .tick     (tick),
        .upd      (upd),
        .cap_cnt  (cap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timing from the edge count since reset, data from a history of d.
    initial begin
        int unsigned      n;
        logic [WIDTH-1:0] m_q;
        logic             m_upd;
        logic [CNT_W-1:0] m_cnt;
        logic [WIDTH-1:0] hist[$];
        logic [WIDTH-1:0] ds;
        logic             slow_pre, tick_pre, ld;
        n = 0; m_q = '0; m_upd = 1'b0; m_cnt = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; m_q = '0; m_upd = 1'b0; m_cnt = '0;
                hist.delete();
                sb.delete();
            end else begin
                slow_pre = ((n / DIV_COUNT) % 2) == 1;
                tick_pre = (n % DIV_COUNT) == DIV_COUNT - 1;
                ds = (hist.size() == SYNC_STAGES) ? hist[0] : '0;
                hist.push_back(d);
                if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
                case (mode)
                    2'b00:   ld = slow_pre;
                    2'b01:   ld = tick_pre && !slow_pre;
                    2'b10:   ld = tick_pre && slow_pre;
                    default: ld = 1'b1;
                endcase
                if (freeze) ld = 1'b0;
                if (ld) begin
                    m_q   = ds;
                    m_cnt = m_cnt + 1'b1;
                end
                m_upd = ld;
                n++;
                sb.push_back('{q: m_q, slow: ((n / DIV_COUNT) % 2) == 1,
                               tick: (n % DIV_COUNT) == DIV_COUNT - 1, upd: m_upd, cnt: m_cnt});
            end
        end
    end

    // Monitor: every out-of-reset cycle presents a full output set to compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", q, e.q);
                chk("slow_clk", slow_clk, e.slow);
                chk("tick", tick, e.tick);
                chk("upd", upd, e.upd);
                chk("cap_cnt", cap_cnt, e.cnt);
            end
        end
    end

    task automatic drive(input int cycles, input logic [1:0] m, input logic frz,
                         input bit rnd_d, input logic [WIDTH-1:0] dv);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            mode   = m;
            freeze = frz;
            d      = rnd_d ? WIDTH'($urandom) : dv;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_slow_clk", slow_clk, 0);
        chk("rst_tick", tick, 0);
        chk("rst_upd", upd, 0);
        chk("rst_cap_cnt", cap_cnt, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; d = '0; mode = 2'b11; freeze = 1'b0;
        repeat (3) @(posedge clk);
        chk("init_q", q, 0);
        chk("init_cap_cnt", cap_cnt, 0);
        #3 rst_n = 1'b1;

        drive(24, 2'b11, 1'b0, 1'b1, '0);
        apply_reset();
        // Pass-through long enough for cap_cnt to wrap.
        drive(270, 2'b11, 1'b0, 1'b1, '0);
        for (int k = 0; k < 5; k++) begin
            drive(4, 2'b00, 1'b0, 1'b0, 4'd5);
            drive(4, 2'b00, 1'b0, 1'b0, 4'd9);
        end
        drive(40, 2'b01, 1'b0, 1'b1, '0);
        drive(40, 2'b10, 1'b0, 1'b1, '0);
        drive(3, 2'b01, 1'b0, 1'b0, 4'd0);
        drive(12, 2'b01, 1'b1, 1'b0, 4'hF);
        drive(16, 2'b01, 1'b0, 1'b0, 4'hF);
        drive(13, 2'b11, 1'b0, 1'b1, '0);
        drive(20, 2'b01, 1'b0, 1'b1, '0);
        for (int k = 0; k < 40; k++) begin
            drive(int'($urandom_range(1, 9)), 2'($urandom), ($urandom_range(0, 3) == 0), 1'b1, '0);
        end
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            drive(int'($urandom_range(1, 9)), 2'($urandom), ($urandom_range(0, 4) == 0), 1'b1, '0);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
